// File: rtl/chan_link_pkg.sv
// Shared channel-link definitions: frame field layout, framer state encoding
// and helpers that build header, trailer and byte-masked payload words.
package chan_link_pkg;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam int         CNT_W     = 11;
  localparam int         CSUM_W    = 16;

  // Header word layout: {magic[7:0], seq[7:0], C_in, 15'h0}
  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_SEQ_LSB   = 16;
  localparam int HDR_CIN_BIT   = 15;

  // Trailer word layout: {C, keep[3:0], count[10:0], csum[15:0]}
  localparam int TRL_C_BIT    = 31;
  localparam int TRL_KEEP_LSB = 27;
  localparam int TRL_CNT_LSB  = 16;
  localparam int TRL_CSUM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY,
    TRL
  } framer_state_e;

  function automatic logic [31:0] mask_word(input logic [31:0] data,
                                            input logic [3:0]  keep);
    logic [31:0] w_word;
    for (int b = 0; b < 4; b++) begin
      w_word[8*b +: 8] = keep[b] ? data[8*b +: 8] : 8'h00;
    end
    return w_word;
  endfunction

  function automatic logic [31:0] make_header(input logic [7:0] seq,
                                              input logic       cin);
    logic [31:0] w_word;
    w_word                      = '0;
    w_word[HDR_MAGIC_LSB +: 8]  = HDR_MAGIC;
    w_word[HDR_SEQ_LSB +: 8]    = seq;
    w_word[HDR_CIN_BIT]         = cin;
    return w_word;
  endfunction

  function automatic logic [31:0] make_trailer(input logic              cont,
                                               input logic [3:0]        keep,
                                               input logic [CNT_W-1:0]  count,
                                               input logic [CSUM_W-1:0] csum);
    logic [31:0] w_word;
    w_word                          = '0;
    w_word[TRL_C_BIT]               = cont;
    w_word[TRL_KEEP_LSB +: 4]       = keep;
    w_word[TRL_CNT_LSB +: CNT_W]    = count;
    w_word[TRL_CSUM_LSB +: CSUM_W]  = csum;
    return w_word;
  endfunction

endpackage

// File: rtl/chan_tx_csum.sv
// Running XOR of byte-masked payload words for one frame, folded to 16 bits
// for the trailer checksum field.
module chan_tx_csum
  import chan_link_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic [31:0]       i_data,
  input  logic [3:0]        i_keep,
  output logic [CSUM_W-1:0] o_fold
);

  logic [31:0] r_acc;

  // Clear wins over enable; the framer never asserts both in one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc ^ mask_word(i_data, i_keep);
    end
  end

  assign o_fold = r_acc[31:16] ^ r_acc[15:0];

endmodule

// File: rtl/chan_tx_framer.sv
// Wraps an AXI4-stream payload into header/payload/trailer link frames,
// splitting long payloads. Checksum accumulator built only with CHAN_TX_FRAMER_CSUM_EN.
module chan_tx_framer
  import chan_link_pkg::*;
#(
  parameter int MAX_WORDS = 1024
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic [31:0] s_axis_tdata,
  input  logic [3:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [7:0]  seq_num,
  output logic [15:0] frames_sent
);

  localparam logic [CNT_W-1:0] MaxWords = CNT_W'(MAX_WORDS);

  framer_state_e     r_state;
  logic [31:0]       r_tdata;
  logic              r_tvalid;
  logic              r_tlast;
  logic [CNT_W-1:0]  r_count;
  logic              r_cont;
  logic [3:0]        r_keep;
  logic [7:0]        r_seq;
  logic [15:0]       r_frames;

  logic              w_free;
  logic              w_accept;
  logic              w_last_word;
  logic [CSUM_W-1:0] w_csum;

  assign w_free        = !r_tvalid || m_axis_tready;
  assign s_axis_tready = (r_state == PAY) && w_free;
  assign w_accept      = s_axis_tready && s_axis_tvalid;
  assign w_last_word   = s_axis_tlast || ((r_count + CNT_W'(1)) == MaxWords);

`ifdef CHAN_TX_FRAMER_CSUM_EN
  logic w_load_trl;

  assign w_load_trl = (r_state == TRL) && w_free;

  chan_tx_csum u_csum (
    .i_clk   (axis_aclk),
    .i_rst_n (axis_aresetn),
    .i_clear (w_load_trl),
    .i_en    (w_accept),
    .i_data  (s_axis_tdata),
    .i_keep  (s_axis_tkeep),
    .o_fold  (w_csum)
  );
`else
  assign w_csum = '0;
`endif

  // Each state loads the output register only when it is free; otherwise the
  // held word stays put, which keeps tdata/tlast stable under backpressure.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_state  <= IDLE;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_count  <= '0;
      r_cont   <= 1'b0;
      r_keep   <= '0;
      r_seq    <= '0;
      r_frames <= '0;
    end else begin
      if (r_tvalid && r_tlast && m_axis_tready) begin
        r_frames <= r_frames + 16'd1;
      end

      case (r_state)
        IDLE: begin
          if (w_free) begin
            if (s_axis_tvalid) begin
              r_tdata  <= make_header(r_seq, 1'b0);
              r_tvalid <= 1'b1;
              r_tlast  <= 1'b0;
              r_state  <= PAY;
            end else begin
              r_tvalid <= 1'b0;
            end
          end
        end

        HDR: begin
          if (w_free) begin
            r_tdata  <= make_header(r_seq, 1'b1);
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
            r_state  <= PAY;
          end
        end

        PAY: begin
          if (w_accept) begin
            r_tdata  <= mask_word(s_axis_tdata, s_axis_tkeep);
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
            r_count  <= r_count + CNT_W'(1);
            r_keep   <= s_axis_tkeep;
            if (w_last_word) begin
              r_cont  <= !s_axis_tlast;
              r_state <= TRL;
            end
          end else if (w_free) begin
            r_tvalid <= 1'b0;
          end
        end

        TRL: begin
          if (w_free) begin
            r_tdata  <= make_trailer(r_cont, r_cont ? 4'hF : r_keep, r_count, w_csum);
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b1;
            r_count  <= '0;
            r_seq    <= r_seq + 8'd1;
            r_state  <= r_cont ? HDR : IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = 4'hF;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign seq_num       = r_seq;
  assign frames_sent   = r_frames;

endmodule

// File: tb/tb_chan_tx_framer.sv
// Self-checking bench for chan_tx_framer: directed frame scenarios plus
// randomized payloads compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_chan_tx_framer;

  localparam int MW = 4;

`ifdef CHAN_TX_FRAMER_CSUM_EN
  localparam logic [31:0] PartTrailer = 32'h60031111;
`else
  localparam logic [31:0] PartTrailer = 32'h60030000;
`endif

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] sTdata = '0;
  logic [3:0]  sTkeep = '0;
  logic        sTvalid = 1'b0;
  logic        sTlast = 1'b0;
  logic        sTready;
  logic [31:0] mTdata;
  logic [3:0]  mTkeep;
  logic        mTvalid;
  logic        mTlast;
  logic        mTready;
  logic [7:0]  seqNum;
  logic [15:0] framesSent;
  logic        readyBase = 1'b1;
  logic        forceLow = 1'b0;
  int          readyMode = 0;

  int          checks = 0;
  int          errors = 0;
  beat_t       expQ[$];
  logic [31:0] captured[$];
  bit          modelOn = 1'b0;
  int          modelSeq = 0;
  int          modelFrames = 0;
  logic [31:0] payWords[$];
  logic [3:0]  payKeeps[$];
  bit          prevHold = 1'b0;
  logic [31:0] prevData = '0;
  logic        prevLast = 1'b0;

  assign mTready = readyBase && !forceLow;

  always #5 clk = ~clk;

  chan_tx_framer #(.MAX_WORDS(MW)) dut (
    .axis_aclk     (clk),
    .axis_aresetn  (aresetn),
    .s_axis_tdata  (sTdata),
    .s_axis_tkeep  (sTkeep),
    .s_axis_tvalid (sTvalid),
    .s_axis_tlast  (sTlast),
    .s_axis_tready (sTready),
    .m_axis_tdata  (mTdata),
    .m_axis_tkeep  (mTkeep),
    .m_axis_tvalid (mTvalid),
    .m_axis_tlast  (mTlast),
    .m_axis_tready (mTready),
    .seq_num       (seqNum),
    .frames_sent   (framesSent)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] maskBytes(input logic [31:0] d, input logic [3:0] k);
    logic [31:0] w;
    w = d;
    for (int b = 0; b < 4; b++) if (!k[b]) w[8*b +: 8] = 8'h00;
    return w;
  endfunction

  // Frame-level reference: chop the payload into MW-sized chunks, each
  // wrapped by a header and a trailer describing that chunk.
  function automatic void buildModel();
    int n;
    n = payWords.size();
    for (int s = 0; s < n; s += MW) begin
      int          len;
      bit          cont;
      logic [31:0] x;
      logic [31:0] w;
      logic [3:0]  k;
      logic [15:0] csum;
      beat_t       b;
      len  = (n - s < MW) ? (n - s) : MW;
      cont = (s + len < n);
      x    = '0;
      b.data = {8'hA5, 8'(modelSeq), (s > 0), 15'h0};
      b.last = 1'b0;
      expQ.push_back(b);
      for (int i = 0; i < len; i++) begin
        w = maskBytes(payWords[s+i], payKeeps[s+i]);
        x = x ^ w;
        b.data = w;
        b.last = 1'b0;
        expQ.push_back(b);
      end
      k = cont ? 4'hF : payKeeps[s+len-1];
`ifdef CHAN_TX_FRAMER_CSUM_EN
      csum = x[31:16] ^ x[15:0];
`else
      csum = 16'h0000;
`endif
      b.data = {cont, k, 11'(len), csum};
      b.last = 1'b1;
      expQ.push_back(b);
      modelSeq = (modelSeq + 1) % 256;
      modelFrames++;
    end
  endfunction

  // Ready source: steady high or random, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    readyBase = (readyMode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Compare process: every output handshake is checked against the model,
  // and a stalled word must not change while it waits.
  always @(negedge clk) begin
    beat_t b;
    if (aresetn) begin
      if (mTvalid) begin
        checkOutput("tkeep", 32'(mTkeep), 32'h0000000F);
        if (prevHold) begin
          checkOutput("holdData", mTdata, prevData);
          checkOutput("holdLast", 32'(mTlast), 32'(prevLast));
        end
        if (mTready) begin
          captured.push_back(mTdata);
          if (modelOn) begin
            if (expQ.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpectedBeat: got %h, expected no output", mTdata);
            end else begin
              b = expQ.pop_front();
              checkOutput("modelData", mTdata, b.data);
              checkOutput("modelLast", 32'(mTlast), 32'(b.last));
            end
          end
        end
      end
      prevHold = mTvalid && !mTready;
      prevData = mTdata;
      prevLast = mTlast;
    end else begin
      prevHold = 1'b0;
    end
  end

  task automatic driveWord(input logic [31:0] d, input logic [3:0] k, input logic l, input int gapMax);
    int budget;
    bit acc;
    repeat ($urandom_range(0, gapMax)) begin
      @(posedge clk);
      #1;
    end
    sTdata  = d;
    sTkeep  = k;
    sTlast  = l;
    sTvalid = 1'b1;
    budget  = 0;
    acc     = 1'b0;
    while (!acc && budget < 2000) begin
      @(negedge clk);
      acc = sTready;
      @(posedge clk);
      #1;
      budget++;
    end
    sTvalid = 1'b0;
    sTlast  = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL inputTimeout: word %h not accepted, expected acceptance", d);
    end
  endtask

  task automatic applyStimulus(input int gapMax);
    buildModel();
    for (int i = 0; i < payWords.size(); i++) begin
      driveWord(payWords[i], payKeeps[i], (i == payWords.size() - 1), gapMax);
    end
  endtask

  task automatic waitDrain();
    int budget;
    budget = 0;
    while (expQ.size() != 0 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drainTimeout: %0d beats left, expected 0", expQ.size());
      expQ.delete();
    end
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    modelOn = 1'b0;
    sTvalid = 1'b0;
    sTlast  = 1'b0;
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    checkOutput("rstTvalid", 32'(mTvalid), 32'h0);
    checkOutput("rstTdata", mTdata, 32'h0);
    checkOutput("rstTlast", 32'(mTlast), 32'h0);
    checkOutput("rstSready", 32'(sTready), 32'h0);
    checkOutput("rstSeq", 32'(seqNum), 32'h0);
    checkOutput("rstFrames", 32'(framesSent), 32'h0);
    expQ.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    captured.delete();
    modelSeq    = 0;
    modelFrames = 0;
    modelOn     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] keepTbl [5];
    keepTbl = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

    $display("[TB] reset state");
    resetDut();

    $display("[TB] partial last word");
    payWords = {32'h11112222, 32'h33334444, 32'h5555ABCD};
    payKeeps = {4'hF, 4'hF, 4'hC};
    applyStimulus(0);
    waitDrain();
    checkOutput("partCount", 32'(captured.size()), 32'd5);
    if (captured.size() == 5) begin
      checkOutput("partHdr", captured[0], 32'hA5000000);
      checkOutput("partW1", captured[1], 32'h11112222);
      checkOutput("partW2", captured[2], 32'h33334444);
      checkOutput("partW3", captured[3], 32'h55550000);
      checkOutput("partTrl", captured[4], PartTrailer);
    end
    checkOutput("partSeq", 32'(seqNum), 32'd1);
    checkOutput("partFrames", 32'(framesSent), 32'd1);

    $display("[TB] split payload");
    resetDut();
    payWords = {32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 32'h05050505, 32'h06060606};
    payKeeps = {4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    applyStimulus(0);
    waitDrain();
    checkOutput("splitCount", 32'(captured.size()), 32'd10);
    if (captured.size() == 10) begin
      checkOutput("splitHdr0", captured[0], 32'hA5000000);
      checkOutput("splitW4", captured[4], 32'h04040404);
      checkOutput("splitTrl0", 32'(captured[5][31:16]), 32'h0000F804);
      checkOutput("splitHdr1", captured[6], 32'hA5018000);
      checkOutput("splitW6", captured[8], 32'h06060606);
      checkOutput("splitTrl1", 32'(captured[9][31:16]), 32'h00007802);
    end
    checkOutput("splitFrames", 32'(framesSent), 32'd2);

    $display("[TB] exact fill");
    resetDut();
    payWords = {32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 32'hAAAA0004};
    payKeeps = {4'hF, 4'hF, 4'hF, 4'hF};
    applyStimulus(0);
    waitDrain();
    checkOutput("exactCount", 32'(captured.size()), 32'd6);
    if (captured.size() == 6) begin
      checkOutput("exactTrl", 32'(captured[5][31:16]), 32'h00007804);
    end
    repeat (6) begin
      @(negedge clk);
      checkOutput("exactIdle", 32'(mTvalid), 32'h0);
    end
    @(posedge clk);
    #1;

    $display("[TB] backpressure");
    payWords = {32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hB0000004,
                32'hB0000005, 32'hB0000006, 32'hB0000007};
    payKeeps = {4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hE};
    fork
      applyStimulus(0);
      begin
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        forceLow = 1'b1;
        repeat (5) begin
          @(negedge clk);
          checkOutput("bpTvalid", 32'(mTvalid), 32'h1);
          checkOutput("bpSready", 32'(sTready), 32'h0);
          @(posedge clk);
          #1;
        end
        forceLow = 1'b0;
      end
    join
    waitDrain();
    checkOutput("bpFrames", 32'(framesSent), 32'(modelFrames));

    $display("[TB] reset during payload");
    modelOn = 1'b0;
    driveWord(32'hDEADBEEF, 4'hF, 1'b0, 0);
    driveWord(32'h01234567, 4'hF, 1'b0, 0);
    resetDut();
    payWords = {32'h0BADF00D};
    payKeeps = {4'hF};
    applyStimulus(0);
    waitDrain();
    checkOutput("rstPayCount", 32'(captured.size()), 32'd3);
    if (captured.size() == 3) begin
      checkOutput("rstPayHdr", captured[0], 32'hA5000000);
    end

    $display("[TB] randomized payloads");
    readyMode = 1;
    for (int p = 0; p < 40; p++) begin
      int n;
      n = $urandom_range(1, 11);
      payWords.delete();
      payKeeps.delete();
      for (int i = 0; i < n; i++) begin
        payWords.push_back($urandom);
        payKeeps.push_back((i == n - 1) ? keepTbl[$urandom_range(0, 4)] : 4'hF);
      end
      applyStimulus($urandom_range(0, 2));
    end
    waitDrain();
    readyMode = 0;
    checkOutput("randFrames", 32'(framesSent), 32'(modelFrames));
    checkOutput("randSeq", 32'(seqNum), 32'(modelSeq));

    $display("[TB] sequence wrap");
    resetDut();
    for (int f = 0; f < 256; f++) begin
      payWords = {$urandom};
      payKeeps = {4'hF};
      applyStimulus(0);
    end
    waitDrain();
    checkOutput("wrapFrames", 32'(framesSent), 32'd256);
    checkOutput("wrapSeq", 32'(seqNum), 32'd0);
    captured.delete();
    payWords = {32'h12345678};
    payKeeps = {4'hF};
    applyStimulus(0);
    waitDrain();
    checkOutput("wrapCount", 32'(captured.size()), 32'd3);
    if (captured.size() == 3) begin
      checkOutput("wrapHdr", captured[0], 32'hA5000000);
    end
    checkOutput("wrapFrames2", 32'(framesSent), 32'd257);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
